lsu_mem_master: RTL and testbench

//  Core-side load/store initiator for the external data memory. Takes one load/store per handshake from the

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_align.sv | 24 ++
 rtl/lsu_mem_master.sv | 158 +++++++++++++++
 tb/tb_lsu_mem_master.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 codes and helpers for the LSU memory master
package lsu_pkg;
   localparam logic [2:0] F3_B = 3'b000;
   localparam logic [2:0] F3_H = 3'b001;
   localparam logic [2:0] F3_W = 3'b010;
   localparam int LSU_TIMEOUT = 255;
   typedef enum logic [2:0] {S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP} lsu_state_e;
   function automatic logic [3:0] be_mask(input logic [1:0] size);
      return size == F3_B[1:0] ? 4'b0001 : size == F3_H[1:0] ? 4'b0011 : 4'b1111;
   endfunction
   function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
      return store ? (f3 > F3_W) : (f3[1:0] == 2'b11 || f3 == 3'b110);
   endfunction
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane shift and enables for stores, two-beat merge and extension for loads
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] beat0_i,
   input  logic [31:0] beat1_i,
   output logic [7:0]  be_o,
   output logic [63:0] wdata_o,
   output logic        cross_o,
   output logic [31:0] rdata_o
);
   logic [31:0] sh;
   logic        sx;
   assign be_o    = {4'b0000, be_mask(funct3_i[1:0])} << off_i;
   assign wdata_o = {32'h0, wdata_i} << {off_i, 3'b000};
   assign cross_o = |be_o[7:4];
   assign sh      = 32'({beat1_i, beat0_i} >> {off_i, 3'b000});
   assign sx      = !funct3_i[2];
   assign rdata_o = funct3_i[1:0] == F3_B[1:0] ? {{24{sx & sh[7]}}, sh[7:0]} :
                    funct3_i[1:0] == F3_H[1:0] ? {{16{sx & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator for a req/gnt/rvalid word bus.
// LSU_MISALIGN_SPLIT_EN splits word-crossing accesses into two beats; otherwise they fault.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = LSU_TIMEOUT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            lsu_valid_i,
   output logic            lsu_ready_o,
   input  logic            lsu_store_i,
   input  logic [2:0]      lsu_funct3_i,
   input  logic [XLEN-1:0] lsu_addr_i,
   input  logic [XLEN-1:0] lsu_wdata_i,
   output logic            lsu_rvalid_o,
   output logic [XLEN-1:0] lsu_rdata_o,
   output logic            lsu_err_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [3:0]      mem_be_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   input  logic            mem_err_i
);
   localparam int TW = cnt_width(TIMEOUT);
`ifdef LSU_MISALIGN_SPLIT_EN
   localparam logic SPLIT = 1'b1;
`else
   localparam logic SPLIT = 1'b0;
`endif
   lsu_state_e      state_q;
   logic [TW-1:0]   cnt_q;
   logic [2:0]      funct3_q;
   logic [1:0]      off_q;
   logic            store_q, split_q;
   logic [31:0]     data0_q, wd1_q;
   logic [3:0]      be1_q;
   logic            mem_req_q, mem_we_q, rvalid_q, err_q;
   logic [XLEN-1:0] mem_addr_q, mem_wdata_q, rdata_q;
   logic [3:0]      mem_be_q;
   logic            idle, in_req, busy, progress, abort, illegal, a_cross;
   logic [2:0]      a_f3;
   logic [1:0]      a_off;
   logic [31:0]     a_b0, a_rd;
   logic [7:0]      a_be;
   logic [63:0]     a_wd;
   assign idle     = state_q == S_IDLE;
   assign in_req   = state_q == S_REQ0 || state_q == S_REQ1;
   assign busy     = in_req || state_q == S_WAIT0 || state_q == S_WAIT1;
   assign progress = in_req ? mem_gnt_i : mem_rvalid_i;
   assign abort    = busy && !progress && cnt_q == TW'(TIMEOUT - 1);
   assign illegal  = f3_illegal(lsu_store_i, lsu_funct3_i);
   // Request fields feed the aligner at accept; latched copies drive the load merge.
   assign a_f3     = idle ? lsu_funct3_i : funct3_q;
   assign a_off    = idle ? lsu_addr_i[1:0] : off_q;
   assign a_b0     = state_q == S_WAIT1 ? data0_q : mem_rdata_i;
   lsu_align u_align (
      .funct3_i (a_f3),
      .off_i    (a_off),
      .wdata_i  (lsu_wdata_i),
      .beat0_i  (a_b0),
      .beat1_i  (mem_rdata_i),
      .be_o     (a_be),
      .wdata_o  (a_wd),
      .cross_o  (a_cross),
      .rdata_o  (a_rd)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         funct3_q    <= '0;
         off_q       <= '0;
         store_q     <= 1'b0;
         split_q     <= 1'b0;
         data0_q     <= '0;
         wd1_q       <= '0;
         be1_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         cnt_q    <= busy && !progress ? cnt_q + 1'b1 : '0;
         if (abort) begin
            state_q   <= S_RESP;
            cnt_q     <= '0;
            mem_req_q <= 1'b0;
            rvalid_q  <= 1'b1;
            err_q     <= 1'b1;
            rdata_q   <= '0;
         end else begin
            case (state_q)
               S_IDLE: if (lsu_valid_i) begin
                  funct3_q <= lsu_funct3_i;
                  off_q    <= lsu_addr_i[1:0];
                  store_q  <= lsu_store_i;
                  split_q  <= a_cross;
                  be1_q    <= a_be[7:4];
                  wd1_q    <= a_wd[63:32];
                  if (illegal || (a_cross && !SPLIT)) begin
                     state_q  <= S_RESP;
                     rvalid_q <= 1'b1;
                     err_q    <= 1'b1;
                     rdata_q  <= '0;
                  end else begin
                     state_q     <= S_REQ0;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= lsu_store_i;
                     mem_addr_q  <= {lsu_addr_i[XLEN-1:2], 2'b00};
                     mem_be_q    <= a_be[3:0];
                     mem_wdata_q <= a_wd[31:0];
                  end
               end
               S_REQ0, S_REQ1: if (mem_gnt_i) begin
                  state_q   <= state_q == S_REQ0 ? S_WAIT0 : S_WAIT1;
                  mem_req_q <= 1'b0;
               end
               S_WAIT0, S_WAIT1: if (mem_rvalid_i) begin
                  if (state_q == S_WAIT0 && split_q && !mem_err_i) begin
                     state_q     <= S_REQ1;
                     data0_q     <= mem_rdata_i;
                     mem_req_q   <= 1'b1;
                     mem_addr_q  <= mem_addr_q + 'd4;
                     mem_be_q    <= be1_q;
                     mem_wdata_q <= wd1_q;
                  end else begin
                     state_q  <= S_RESP;
                     rvalid_q <= 1'b1;
                     err_q    <= mem_err_i;
                     rdata_q  <= (mem_err_i || store_q) ? '0 : a_rd;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end
   assign lsu_ready_o  = idle;
   assign lsu_rvalid_o = rvalid_q;
   assign lsu_rdata_o  = rdata_q;
   assign lsu_err_o    = err_q;
   assign mem_req_o    = mem_req_q;
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_be_o     = mem_be_q;
   assign mem_wdata_o  = mem_wdata_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed scenarios for the LSU memory master, driven and sampled on falling edges
module tb_lsu_mem_master;
   localparam int TIMEOUT = 255;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        lsu_valid = 1'b0, lsu_store = 1'b0, lsu_ready, lsu_rvalid, lsu_err;
   logic [2:0]  lsu_funct3 = 3'b000;
   logic [31:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
   logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
   logic [3:0]  mem_be;
   int          checks = 0, errors = 0;

   lsu_mem_master #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_store_i(lsu_store),
      .lsu_funct3_i(lsu_funct3), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
      .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata), .lsu_err_o(lsu_err),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
      .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
      .mem_rdata_i(mem_rdata), .mem_err_i(mem_err)
   );

   always #5 clk = ~clk;

   task automatic start(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      lsu_valid = 1'b1; lsu_store = st; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
      @(negedge clk);
      lsu_valid = 1'b0;
   endtask

   task automatic grant();
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d, input logic e);
      mem_rvalid = 1'b1; mem_rdata = d; mem_err = e;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_err = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== 70'h0) begin
         errors++; $display("FAIL reset_bus got %h exp 0", {mem_req, mem_we, mem_addr, mem_be, mem_wdata});
      end
      checks++;
      if ({lsu_rvalid, lsu_err, lsu_rdata} !== 34'h0) begin
         errors++; $display("FAIL reset_resp got %h exp 0", {lsu_rvalid, lsu_err, lsu_rdata});
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({lsu_ready, mem_req} !== 2'b10) begin
         errors++; $display("FAIL reset_ready got %b exp 10", {lsu_ready, mem_req});
      end
   endtask

   task automatic test_lb();
      start(1'b0, 3'b000, 32'h103, 32'h0);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, 1'b0, 32'h100, 4'b1000}) begin
         errors++; $display("FAIL lb_req got %h exp %h", {mem_req, mem_we, mem_addr, mem_be}, {1'b1, 1'b0, 32'h100, 4'b1000});
      end
      grant();
      checks++;
      if ({mem_req, lsu_rvalid} !== 2'b00) begin
         errors++; $display("FAIL lb_wait got %b exp 00", {mem_req, lsu_rvalid});
      end
      respond(32'h80FF_0000, 1'b0);
      checks++;
      if ({lsu_rvalid, lsu_err, lsu_rdata} !== {2'b10, 32'hFFFF_FF80}) begin
         errors++; $display("FAIL lb_resp got %h exp %h", {lsu_rvalid, lsu_err, lsu_rdata}, {2'b10, 32'hFFFF_FF80});
      end
      @(negedge clk);
      checks++;
      if ({lsu_rvalid, lsu_ready} !== 2'b01) begin
         errors++; $display("FAIL lb_idle got %b exp 01", {lsu_rvalid, lsu_ready});
      end
   endtask

   task automatic test_sh();
      start(1'b1, 3'b001, 32'h102, 32'h0000_BEEF);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== {2'b11, 32'h100, 4'b1100, 32'hBEEF_0000}) begin
         errors++; $display("FAIL sh_req got %h exp %h", {mem_req, mem_we, mem_addr, mem_be, mem_wdata}, {2'b11, 32'h100, 4'b1100, 32'hBEEF_0000});
      end
      grant();
      respond(32'h5555_5555, 1'b0);
      checks++;
      if ({lsu_rvalid, lsu_err, lsu_rdata} !== {2'b10, 32'h0}) begin
         errors++; $display("FAIL sh_resp got %h exp %h", {lsu_rvalid, lsu_err, lsu_rdata}, {2'b10, 32'h0});
      end
      @(negedge clk);
   endtask

   task automatic test_gnt_delay();
      logic held = 1'b1;
      start(1'b0, 3'b010, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         held &= ({mem_req, mem_we, mem_addr, mem_be} === {2'b10, 32'h0, 4'b1111});
         if (i < 3) @(negedge clk);
      end
      checks++;
      if (held !== 1'b1) begin
         errors++; $display("FAIL delay_hold got %b exp 1", held);
      end
      grant();
      checks++;
      if (mem_req !== 1'b0) begin
         errors++; $display("FAIL delay_drop got %b exp 0", mem_req);
      end
      respond(32'h1234_5678, 1'b0);
      checks++;
      if ({lsu_rvalid, lsu_err, lsu_rdata} !== {2'b10, 32'h1234_5678}) begin
         errors++; $display("FAIL delay_resp got %h exp %h", {lsu_rvalid, lsu_err, lsu_rdata}, {2'b10, 32'h1234_5678});
      end
      @(negedge clk);
   endtask

   task automatic test_extend();
      logic [2:0]  f3;
      logic [31:0] a, w, er;
      logic [3:0]  eb;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       begin f3 = 3'b001; a = 32'h101; w = 32'h00AB_CD00; eb = 4'b0110; er = 32'hFFFF_ABCD; end
            1:       begin f3 = 3'b101; a = 32'h102; w = 32'h8001_0000; eb = 4'b1100; er = 32'h0000_8001; end
            default: begin f3 = 3'b100; a = 32'h111; w = 32'h0000_9A00; eb = 4'b0010; er = 32'h0000_009A; end
         endcase
         start(1'b0, f3, a, 32'h0);
         checks++;
         if ({mem_addr, mem_be} !== {a[31:2], 2'b00, eb}) begin
            errors++; $display("FAIL ext%0d_req got %h exp %h", i, {mem_addr, mem_be}, {a[31:2], 2'b00, eb});
         end
         grant();
         respond(w, 1'b0);
         checks++;
         if ({lsu_rvalid, lsu_err, lsu_rdata} !== {2'b10, er}) begin
            errors++; $display("FAIL ext%0d_resp got %h exp %h", i, {lsu_rvalid, lsu_err, lsu_rdata}, {2'b10, er});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_illegal();
      for (int i = 0; i < 2; i++) begin
         start(i == 1, i == 1 ? 3'b011 : 3'b110, 32'h200, 32'h0);
         checks++;
         if ({mem_req, lsu_rvalid, lsu_err, lsu_rdata} !== {3'b011, 32'h0}) begin
            errors++; $display("FAIL illegal%0d got %h exp %h", i, {mem_req, lsu_rvalid, lsu_err, lsu_rdata}, {3'b011, 32'h0});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_misalign();
      start(1'b0, 3'b010, 32'h102, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
      checks++;
      if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h100, 4'b1100}) begin
         errors++; $display("FAIL split_beat0 got %h exp %h", {mem_req, mem_addr, mem_be}, {1'b1, 32'h100, 4'b1100});
      end
      grant();
      respond(32'hAABB_CCDD, 1'b0);
      checks++;
      if ({mem_req, mem_addr, mem_be, lsu_rvalid} !== {1'b1, 32'h104, 4'b0011, 1'b0}) begin
         errors++; $display("FAIL split_beat1 got %h exp %h", {mem_req, mem_addr, mem_be, lsu_rvalid}, {1'b1, 32'h104, 4'b0011, 1'b0});
      end
      grant();
      respond(32'h1122_3344, 1'b0);
      checks++;
      if ({lsu_rvalid, lsu_err, lsu_rdata} !== {2'b10, 32'h3344_AABB}) begin
         errors++; $display("FAIL split_resp got %h exp %h", {lsu_rvalid, lsu_err, lsu_rdata}, {2'b10, 32'h3344_AABB});
      end
`else
      checks++;
      if ({mem_req, lsu_rvalid, lsu_err} !== 3'b011) begin
         errors++; $display("FAIL misalign got %b exp 011", {mem_req, lsu_rvalid, lsu_err});
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_bus_err();
      start(1'b0, 3'b010, 32'h40, 32'h0);
      grant();
      respond(32'hFFFF_FFFF, 1'b1);
      checks++;
      if ({lsu_rvalid, lsu_err, lsu_rdata} !== {2'b11, 32'h0}) begin
         errors++; $display("FAIL bus_err got %h exp %h", {lsu_rvalid, lsu_err, lsu_rdata}, {2'b11, 32'h0});
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int cyc = 0;
      start(1'b0, 3'b010, 32'h4, 32'h0);
      grant();
      while (!lsu_rvalid && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc < TIMEOUT - 2 || cyc > TIMEOUT + 2) begin
         errors++; $display("FAIL timeout_cycles got %0d exp %0d..%0d", cyc, TIMEOUT - 2, TIMEOUT + 2);
      end
      checks++;
      if ({lsu_rvalid, lsu_err, mem_req} !== 3'b110) begin
         errors++; $display("FAIL timeout_resp got %b exp 110", {lsu_rvalid, lsu_err, mem_req});
      end
      @(negedge clk);
      checks++;
      if (lsu_ready !== 1'b1) begin
         errors++; $display("FAIL timeout_ready got %b exp 1", lsu_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic seen = 1'b0;
      start(1'b0, 3'b010, 32'h8, 32'h0);
      grant();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({lsu_ready, mem_req, mem_addr, mem_be, lsu_rvalid, lsu_err} !== {1'b1, 39'h0}) begin
         errors++; $display("FAIL midrst_out got %h exp %h", {lsu_ready, mem_req, mem_addr, mem_be, lsu_rvalid, lsu_err}, {1'b1, 39'h0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      respond(32'hCAFE_F00D, 1'b0);
      for (int i = 0; i < 3; i++) begin
         seen |= lsu_rvalid;
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL midrst_stray got %b exp 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      start(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
      checks++;
      if ({mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF}) begin
         errors++; $display("FAIL b2b_sw got %h exp %h", {mem_we, mem_addr, mem_be, mem_wdata}, {1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF});
      end
      grant();
      respond(32'h0, 1'b0);
      checks++;
      if ({lsu_rvalid, lsu_ready} !== 2'b10) begin
         errors++; $display("FAIL b2b_resp got %b exp 10", {lsu_rvalid, lsu_ready});
      end
      @(negedge clk);
      start(1'b0, 3'b100, 32'h13, 32'h0);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_be} !== {2'b10, 32'h10, 4'b1000}) begin
         errors++; $display("FAIL b2b_lbu_req got %h exp %h", {mem_req, mem_we, mem_addr, mem_be}, {2'b10, 32'h10, 4'b1000});
      end
      grant();
      respond(32'h9A00_0000, 1'b0);
      checks++;
      if ({lsu_rvalid, lsu_err, lsu_rdata} !== {2'b10, 32'h0000_009A}) begin
         errors++; $display("FAIL b2b_lbu got %h exp %h", {lsu_rvalid, lsu_err, lsu_rdata}, {2'b10, 32'h0000_009A});
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_lb();
      test_sh();
      test_gnt_delay();
      test_extend();
      test_illegal();
      test_misalign();
      test_bus_err();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
